// File: rtl/led_disp_pkg.sv
// Shared encodings for the LED display sequencer: display modes and the all-off pattern.
package led_disp_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_ALT    = 2'b11
  } mode_e;

  localparam int unsigned LED_MAX_W = 32;
  localparam logic [LED_MAX_W-1:0] LED_OFF = '0;

endpackage

// File: rtl/led_tick_gen.sv
// Display-tick prescaler: tick is high for the one cycle where the count sits at TICK_DIV-1.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // tick is registered one count early so it coincides with cnt == TICK_DIV-1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CNT_W'(TICK_DIV - 1)) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == CNT_W'(TICK_DIV - 2));
    end
  end

endmodule

// File: rtl/led_disp_seq.sv
// LED source selector with display modes and minimum dwell per selection.
// Optional brightness PWM is enabled by defining LED_PWM_EN.
module led_disp_seq
  import led_disp_pkg::*;
#(
  parameter int unsigned LED_W    = 7,
  parameter int unsigned NUM_SRC  = 9,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned TICK_DIV = 16,
  parameter int unsigned DWELL    = 4,
  parameter int unsigned PWM_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*LED_W-1:0] src_bus,
  input  logic                     load,
  input  logic [SEL_W-1:0]         sel,
  input  logic [1:0]               mode,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]         bright,
`endif
  output logic                     busy,
  output logic                     pend,
  output logic [LED_W-1:0]         leds_out
);

  localparam int unsigned ROT_W = (LED_W > 2) ? $clog2(LED_W) : 1;
  localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL + 1) : 1;

  if (2**SEL_W < NUM_SRC) begin : g_bad_sel_w
    $error("SEL_W too narrow for NUM_SRC");
  end
  if (PWM_W < 1) begin : g_bad_pwm_w
    $error("PWM_W must be at least 1");
  end

  logic              tick;
  logic [SEL_W-1:0]  act_sel, pend_sel, next_sel;
  mode_e             act_mode, pend_mode, next_mode;
  logic [DW_W-1:0]   dwell_cnt;
  logic [ROT_W-1:0]  rot_off;
  logic              phase;
  logic              expire_c, apply_c, gate_c;
  logic [LED_W-1:0]  pat_c, shown_c;
  logic [2*LED_W-1:0] dbl_c;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Expiry applies a fresh load if present (it supersedes pending), else the pending request
  always_comb begin
    expire_c  = busy && tick && (dwell_cnt == DW_W'(1));
    apply_c   = (load && !busy) || (expire_c && (load || pend));
    next_sel  = load ? sel : pend_sel;
    next_mode = load ? mode_e'(mode) : pend_mode;
  end

  // Pattern select and display mode
  always_comb begin
    pat_c = LED_W'(LED_OFF);
    for (int k = 0; k < NUM_SRC; k++) begin
      if (act_sel == SEL_W'(k)) pat_c = src_bus[k*LED_W +: LED_W];
    end
    dbl_c = {pat_c, pat_c} << rot_off;
    unique case (act_mode)
      MODE_STATIC: shown_c = pat_c;
      MODE_BLINK:  shown_c = phase ? LED_W'(LED_OFF) : pat_c;
      MODE_ROTATE: shown_c = dbl_c[2*LED_W-1 -: LED_W];
      MODE_ALT:    shown_c = phase ? ~pat_c : pat_c;
      default:     shown_c = LED_W'(LED_OFF);
    endcase
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  assign gate_c = (pwm_cnt < bright);
`else
  assign gate_c = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_sel   <= '0;
      act_mode  <= MODE_STATIC;
      pend_sel  <= '0;
      pend_mode <= MODE_STATIC;
      pend      <= 1'b0;
      busy      <= 1'b0;
      dwell_cnt <= '0;
      phase     <= 1'b0;
      rot_off   <= '0;
      leds_out  <= '0;
    end else begin
      if (tick) begin
        phase   <= ~phase;
        rot_off <= (rot_off == ROT_W'(LED_W - 1)) ? '0 : rot_off + ROT_W'(1);
      end

      // Accept restarts the animation but leaves the prescaler free-running
      if (apply_c) begin
        act_sel   <= next_sel;
        act_mode  <= next_mode;
        rot_off   <= '0;
        phase     <= 1'b0;
        busy      <= 1'b1;
        dwell_cnt <= DW_W'(DWELL);
      end else if (busy && tick) begin
        dwell_cnt <= dwell_cnt - DW_W'(1);
        if (expire_c) busy <= 1'b0;
      end

      if (load && busy && !expire_c) begin
        pend      <= 1'b1;
        pend_sel  <= sel;
        pend_mode <= mode_e'(mode);
      end else if (expire_c) begin
        pend <= 1'b0;
      end

      leds_out <= shown_c & {LED_W{gate_c}};
    end
  end

endmodule

// File: tb/tb_led_disp_seq.sv
// Directed self-checking bench for led_disp_seq (TICK_DIV=4, DWELL=2); covers LED_PWM_EN when defined.
module tb_led_disp_seq;

  logic        clk;
  logic        rst_n;
  logic [62:0] src_bus;
  logic        load;
  logic [3:0]  sel;
  logic [1:0]  mode;
  logic [3:0]  bright;
  logic        busy;
  logic        pend;
  logic [6:0]  leds_out;

  logic [6:0]  src [9];
  int          cyc;
  int          tests;
  int          fails;
  int          lit;

  always_comb begin
    for (int k = 0; k < 9; k++) src_bus[k*7 +: 7] = src[k];
  end

  led_disp_seq #(
    .LED_W(7), .NUM_SRC(9), .SEL_W(4), .TICK_DIV(4), .DWELL(2), .PWM_W(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_bus  (src_bus),
    .load     (load),
    .sel      (sel),
    .mode     (mode),
`ifdef LED_PWM_EN
    .bright   (bright),
`endif
    .busy     (busy),
    .pend     (pend),
    .leds_out (leds_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Expected LED drive; with PWM the output register saw pwm count (cyc-1) mod 16
  function automatic logic [6:0] exp_l(input logic [6:0] v);
`ifdef LED_PWM_EN
    return (4'(cyc - 1) < bright) ? v : 7'd0;
`else
    return v;
`endif
  endfunction

  initial begin
    tests = 0; fails = 0; cyc = 0; lit = 0;
    src[0] = 7'b1100110; src[1] = 7'b0000011; src[2] = 7'b1111111;
    src[3] = 7'b0010101; src[4] = 7'b0001000; src[5] = 7'b0110000;
    src[6] = 7'b0000001; src[7] = 7'b1010000; src[8] = 7'b0111100;
    rst_n = 1'b0; load = 1'b1; sel = 4'd3; mode = 2'b00; bright = 4'd15;

    repeat (4) begin
      @(posedge clk);
      #1;
      chk("reset_leds", 32'(leds_out), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_pend", 32'(pend), 32'd0);
    end
    rst_n = 1'b1; load = 1'b0;

    goto(1);  chk("default_src0", 32'(leds_out), 32'(exp_l(src[0])));

    // static
    load = 1'b1; sel = 4'd3; mode = 2'b00;
    goto(2);  load = 1'b0;
    chk("static_busy", 32'(busy), 32'd1);
    goto(3);  chk("static_leds", 32'(leds_out), 32'(exp_l(src[3])));
    goto(7);  chk("static_busy_hold", 32'(busy), 32'd1);
    goto(8);  chk("static_busy_end", 32'(busy), 32'd0);

    // blink
    load = 1'b1; sel = 4'd2; mode = 2'b01;
    goto(9);  load = 1'b0;
    goto(10); chk("blink_on0", 32'(leds_out), 32'(exp_l(7'h7f)));
    goto(12); chk("blink_on1", 32'(leds_out), 32'(exp_l(7'h7f)));
    goto(13); chk("blink_off0", 32'(leds_out), 32'(exp_l(7'h00)));
    goto(16); chk("blink_off1", 32'(leds_out), 32'(exp_l(7'h00)));
    goto(17); chk("blink_on2", 32'(leds_out), 32'(exp_l(7'h7f)));

    // alternate
    load = 1'b1; sel = 4'd2; mode = 2'b11; src[2] = 7'b0101010;
    goto(18); load = 1'b0;
    goto(19); chk("alt_a", 32'(leds_out), 32'(exp_l(7'b0101010)));
    goto(21); chk("alt_b", 32'(leds_out), 32'(exp_l(7'b1010101)));
    goto(24); chk("alt_busy_end", 32'(busy), 32'd0);
    goto(25); chk("alt_a2", 32'(leds_out), 32'(exp_l(7'b0101010)));

    // rotate with wrap
    load = 1'b1; sel = 4'd6; mode = 2'b10;
    goto(26); load = 1'b0;
    goto(27); chk("rot_0", 32'(leds_out), 32'(exp_l(7'b0000001)));
    for (int k = 0; k < 7; k++) begin
      logic [6:0] one;
      one = 7'd1;
      goto(29 + 4*k);
      chk("rot_step", 32'(leds_out), 32'(exp_l(7'(one << ((k + 1) % 7)))));
    end

    // pending, last request wins
    load = 1'b1; sel = 4'd1; mode = 2'b00;
    goto(54); load = 1'b0;
    goto(55); chk("pend_first", 32'(leds_out), 32'(exp_l(src[1])));
    load = 1'b1; sel = 4'd4;
    goto(56); chk("pend_set", 32'(pend), 32'd1);
    sel = 4'd5;
    goto(57); load = 1'b0;
    chk("pend_hold", 32'(pend), 32'd1);
    for (int c = 57; c <= 60; c++) begin
      goto(c);
      chk("pend_keep_src1", 32'(leds_out), 32'(exp_l(src[1])));
    end
    chk("pend_apply_busy", 32'(busy), 32'd1);
    chk("pend_apply_clear", 32'(pend), 32'd0);
    goto(61); chk("pend_shown", 32'(leds_out), 32'(exp_l(src[5])));
    goto(67); chk("pend_dwell_hold", 32'(busy), 32'd1);
    goto(68); chk("pend_dwell_end", 32'(busy), 32'd0);

    // load on the expiry edge with nothing pending
    load = 1'b1; sel = 4'd0; mode = 2'b00;
    goto(69); load = 1'b0;
    goto(75); load = 1'b1; sel = 4'd3;
    goto(76); load = 1'b0;
    chk("sim_busy", 32'(busy), 32'd1);
    chk("sim_pend", 32'(pend), 32'd0);
    goto(77); chk("sim_leds", 32'(leds_out), 32'(exp_l(src[3])));
    goto(83); chk("sim_busy_hold", 32'(busy), 32'd1);
    goto(84); chk("sim_busy_end", 32'(busy), 32'd0);

    // out of range selects
    load = 1'b1; sel = 4'd12;
    goto(85); load = 1'b0;
    goto(86); chk("oor_12", 32'(leds_out), 32'd0);
    goto(92); load = 1'b1; sel = 4'd9;
    goto(93); load = 1'b0;
    goto(94); chk("oor_9", 32'(leds_out), 32'd0);

    goto(100); load = 1'b1; sel = 4'd2; mode = 2'b00;
    goto(101); load = 1'b0;
`ifdef LED_PWM_EN
    bright = 4'd4;
    lit = 0;
    for (int c = 102; c <= 117; c++) begin
      goto(c);
      chk("pwm4_leds", 32'(leds_out), 32'(exp_l(src[2])));
      if (leds_out == src[2]) lit++;
    end
    chk("pwm4_duty", 32'(lit), 32'd4);
    bright = 4'd0;
    lit = 0;
    for (int c = 118; c <= 133; c++) begin
      goto(c);
      if (leds_out != 7'd0) lit++;
    end
    chk("pwm0_dark", 32'(lit), 32'd0);
`else
    goto(102); chk("final_src2", 32'(leds_out), 32'(src[2]));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
